// File: rtl/soc_system_limits_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_limits_pkg
// Purpose  : Shared defaults and state encoding for the burst-read streamer.
// Revision : 1.0 - initial release
// ============================================================================
package soc_system_limits_pkg;

    // Default geometry of the buffer being streamed out
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Controller states: waiting, issuing reads, waiting for the tail to drain
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage : soc_system_limits_pkg
`default_nettype wire

// File: rtl/soc_system_limits_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_limits_reader_fifo
// Purpose  : Synchronous show-ahead skid FIFO with occupancy count. The head
//            entry is visible on head_o whenever the FIFO is not empty.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_limits_reader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful under the count
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule : soc_system_limits_reader_fifo
`default_nettype wire

// File: rtl/soc_system_limits_reader.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_limits_reader
// Purpose  : Reads a burst of words from a 1-cycle-latency buffer and streams
//            them out through a credit-controlled skid FIFO with last marking.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_limits_reader
    import soc_system_limits_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  issued_d;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              w_issue;
    logic              w_issue_last;
    logic              w_credit_ok;
    logic              w_pop;
    logic              w_last_accept;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W:0]   w_head;

    // Read-only master: never writes, always full-word lanes
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;

    // A read may only go out if its data is guaranteed a FIFO slot on return
    assign w_credit_ok  = (int'(w_fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    assign issued_d     = issued_q + LEN_W'(1);
    assign w_issue      = (state_q == ST_RUN) && (issued_q != len_q) && w_credit_ok;
    assign w_issue_last = w_issue && (issued_d == len_q);

    assign avm_chipselect = w_issue;
    assign avm_address    = addr_q;

    // Stream side is driven straight from the FIFO head
    assign st_valid      = ~w_fifo_empty;
    assign st_data       = st_valid ? w_head[DATA_W-1:0] : '0;
    assign st_last       = st_valid & w_head[DATA_W];
    assign w_pop         = st_valid & st_ready;
    assign w_last_accept = w_pop & w_head[DATA_W];

    assign busy = (state_q != ST_IDLE);
    assign done = done_q | ((state_q == ST_DRAIN) && w_last_accept);

    // Read data is captured one cycle after each strobe with its last flag
    soc_system_limits_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, avm_readdata}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    // Burst controller: latches requests, issues reads, tracks the tail
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= w_issue;
            inflight_last_q <= w_issue_last;
            done_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        len_q    <= length;
                        issued_q <= '0;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        issued_q <= issued_d;
                        if (w_issue_last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_accept) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : soc_system_limits_reader
`default_nettype wire

// File: tb/tb_soc_system_limits_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_limits_reader
// Purpose  : Self-checking bench for the burst-read streamer against a
//            behavioural buffer and an expected-word list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_limits_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic [7:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_last;

    logic [31:0] ram [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc;

    int          cs_addr[$];
    int          cs_cyc[$];
    logic [31:0] out_data[$];
    logic        out_last[$];
    int          out_cyc[$];
    int          done_cyc[$];
    int          stab_err;
    bit          busy_seen;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    soc_system_limits_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data valid one cycle after the strobe, garbage otherwise
    always @(posedge clk) avm_readdata <= avm_chipselect ? ram[avm_address] : $urandom;

    // Observe the bus and stream mid-cycle
    always @(negedge clk) begin
        if (avm_chipselect) begin cs_addr.push_back(int'(avm_address)); cs_cyc.push_back(cyc); end
        if (st_valid && st_ready) begin
            out_data.push_back(st_data); out_last.push_back(st_last); out_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_seen = 1'b1;
        if (prev_stall && (!st_valid || st_data !== prev_data || st_last !== prev_last)) stab_err++;
        prev_stall = st_valid && !st_ready;
        prev_data  = st_data;
        prev_last  = st_last;
    end

    // Reference: word i of a burst is the buffer word at (base + i) mod 256
    function automatic logic [31:0] exp_word(input logic [7:0] b, input int i);
        logic [7:0] a;
        a = b + 8'(i);
        return ram[a];
    endfunction

    // Issue one burst; mode 0 ready=1, mode 1 random ready, mode 2 ready low 20 cycles
    task automatic do_burst(input logic [7:0] b, input int len, input int mode, input int second_at);
        int post;
        cs_addr.delete(); cs_cyc.delete(); out_data.delete(); out_last.delete();
        out_cyc.delete(); done_cyc.delete();
        stab_err = 0; busy_seen = 1'b0; post = 0;
        @(posedge clk); #1;
        base_addr = b; length = 9'(len); start = 1'b1; start_cyc = cyc;
        st_ready = (mode == 2) ? 1'b0 : 1'b1;
        if (mode == 1) st_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k < 4000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == second_at) begin base_addr = b + 8'h40; length = 9'd5; start = 1'b1; end
            case (mode)
                1:       st_ready = 1'($urandom_range(0, 1));
                2:       st_ready = (k >= 20);
                default: st_ready = 1'b1;
            endcase
            if (done_cyc.size() > 0) post++;
            if (post > 3) break;
        end
        start = 1'b0; st_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, avm_chipselect, st_valid, st_last} !== 5'b0 || avm_address !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b cs=%b addr=%h valid=%b last=%b required all 0",
                     busy, done, avm_chipselect, avm_address, st_valid, st_last);
        end
        checks++;
        if (avm_write !== 1'b0 || avm_byteenable !== 4'hF) begin
            errors++;
            $display("FAIL constants: got write=%b be=%h required 0/F", avm_write, avm_byteenable);
        end
        reset = 1'b0;
    endtask

    task automatic check_words(input string name, input logic [7:0] b, input int len);
        checks++;
        if (out_data.size() != len) begin
            errors++;
            $display("FAIL %s_count: got %0d words required %0d", name, out_data.size(), len);
        end
        for (int i = 0; i < out_data.size() && i < len; i++) begin
            checks++;
            if (out_data[i] !== exp_word(b, i) || out_last[i] !== (i == len - 1)) begin
                errors++;
                $display("FAIL %s_word%0d: got %h last=%b required %h last=%b", name, i,
                         out_data[i], out_last[i], exp_word(b, i), (i == len - 1));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || stab_err != 0) begin
            errors++;
            $display("FAIL %s_done_stable: got %0d done pulses %0d hold errors required 1 and 0",
                     name, done_cyc.size(), stab_err);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) ram[8'h10 + i] = 32'hA0 + 32'(i);
        do_burst(8'h10, 4, 0, -1);
        check_words("basic", 8'h10, 4);
        for (int i = 0; i < 4 && i < cs_cyc.size(); i++) begin
            checks++;
            if (cs_cyc[i] != start_cyc + 1 + i || cs_addr[i] != 16 + i) begin
                errors++;
                $display("FAIL basic_read%0d: got cycle %0d addr %h required cycle %0d addr %h",
                         i, cs_cyc[i] - start_cyc, cs_addr[i], i + 1, 16 + i);
            end
        end
        checks++;
        if (out_cyc.size() != 4 || out_cyc[3] != out_cyc[0] + 3 || done_cyc.size() != 1
            || done_cyc[0] != out_cyc[3]) begin
            errors++;
            $display("FAIL basic_timing: got %0d words, done count %0d required back-to-back with done on last",
                     out_cyc.size(), done_cyc.size());
        end
    endtask

    task automatic test_wrap();
        do_burst(8'hFE, 4, 0, -1);
        check_words("wrap", 8'hFE, 4);
        checks++;
        if (cs_addr.size() != 4 || cs_addr[0] != 'hFE || cs_addr[1] != 'hFF
            || cs_addr[2] != 0 || cs_addr[3] != 1) begin
            errors++;
            $display("FAIL wrap_addr: got %0d strobes required FE FF 00 01", cs_addr.size());
        end
    endtask

    task automatic test_stall();
        int early;
        do_burst(8'h40, 16, 2, -1);
        early = 0;
        foreach (cs_cyc[i]) if (cs_cyc[i] < start_cyc + 20) early++;
        checks++;
        if (early != 4) begin
            errors++;
            $display("FAIL stall_strobes: got %0d strobes while stalled required 4", early);
        end
        checks++;
        if (cs_addr.size() != 16) begin
            errors++;
            $display("FAIL stall_total: got %0d strobes required 16", cs_addr.size());
        end
        check_words("stall", 8'h40, 16);
    endtask

    task automatic test_zero();
        do_burst(8'h20, 0, 0, -1);
        checks++;
        if (cs_addr.size() != 0 || busy_seen) begin
            errors++;
            $display("FAIL zero_idle: got %0d strobes busy_seen=%b required 0 and 0", cs_addr.size(), busy_seen);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1) begin
            errors++;
            $display("FAIL zero_done: got %0d pulses required 1 pulse one cycle after start", done_cyc.size());
        end
    endtask

    task automatic test_full_random();
        logic [7:0] b;
        b = 8'($urandom);
        do_burst(b, 256, 1, 10);
        check_words("len256", b, 256);
        checks++;
        if (cs_addr.size() != 256) begin
            errors++;
            $display("FAIL len256_strobes: got %0d required 256", cs_addr.size());
        end
        for (int r = 0; r < 3; r++) begin
            int len;
            b = 8'($urandom);
            len = $urandom_range(1, 40);
            do_burst(b, len, 1, -1);
            check_words("random", b, len);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        base_addr = 8'h30; length = 9'd8; start = 1'b1; st_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, avm_chipselect, st_valid, st_last} !== 5'b0 || avm_address !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b cs=%b addr=%h valid=%b last=%b required all 0",
                     busy, done, avm_chipselect, avm_address, st_valid, st_last);
        end
        cs_addr.delete(); out_data.delete(); done_cyc.delete();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_data.size() != 0 || done_cyc.size() != 0 || cs_addr.size() != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d words %0d done %0d strobes required 0",
                     out_data.size(), done_cyc.size(), cs_addr.size());
        end
        do_burst(8'h30, 8, 1, -1);
        check_words("after_reset", 8'h30, 8);
    endtask

    initial begin
        foreach (ram[i]) ram[i] = $urandom;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero();
        test_full_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_soc_system_limits_reader
`default_nettype wire
